// File: rtl/snn_run_ctrl_if.sv
// Signal bundle between the SNN run sequencer and its host, event memory, core and spike sink.
// master is the sequencer; slave is the environment around it.
interface snn_run_ctrl_if #(
    parameter int F  = 48,
    parameter int N  = 96,
    parameter int TW = 16
);
    logic          start;
    logic          abort;
    logic [TW-1:0] num_steps;
    logic          busy;
    logic          done;
    logic          ev_rd_en;
    logic [TW-1:0] ev_rd_addr;
    logic [F-1:0]  ev_rd_data;
    logic          core_clear;
    logic          core_tick;
    logic [F-1:0]  core_event_vec;
    logic [N-1:0]  core_spikes;
    logic          spk_valid;
    logic          spk_ready;
    logic [N-1:0]  spk_data;
    logic [TW-1:0] spk_step;
    logic [31:0]   spike_total;

    modport master (
        input  start, abort, num_steps, ev_rd_data, core_spikes, spk_ready,
        output busy, done, ev_rd_en, ev_rd_addr, core_clear, core_tick,
               core_event_vec, spk_valid, spk_data, spk_step, spike_total
    );

    modport slave (
        output start, abort, num_steps, ev_rd_data, core_spikes, spk_ready,
        input  busy, done, ev_rd_en, ev_rd_addr, core_clear, core_tick,
               core_event_vec, spk_valid, spk_data, spk_step, spike_total
    );
endinterface

// File: rtl/snn_run_ctrl.sv
// SNN run sequencer: clears the core, then fetches/loads/ticks/captures T timesteps and streams spike rows.
// Define SNN_SPIKE_COUNT_EN to build the saturating per-run spike counter (spike_total).
//
// state | meaning
// IDLE  | waiting for start, num_steps latched on accept
// CLEAR | pulse core_clear, reset step index and spike count
// FETCH | issue event-memory read for step t
// LOAD  | register returned event vector towards the core
// TICK  | one-cycle core timestep enable
// CAPT  | capture core spikes into the output row
// ACK   | hold spike row until the sink takes it
// DONE  | completion pulse, event vector cleared
module snn_run_ctrl #(
    parameter int F  = 48,
    parameter int N  = 96,
    parameter int TW = 16
) (
    input  logic           clk,
    input  logic           rstn,
    snn_run_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_LOAD,
        S_TICK,
        S_CAPT,
        S_ACK,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] t_q;
    logic [TW-1:0] num_q;
    logic          busy_q;
    logic          done_q;
    logic          ev_rd_en_q;
    logic          core_clear_q;
    logic          core_tick_q;
    logic          spk_valid_q;
    logic [F-1:0]  ev_vec_q;
    logic [N-1:0]  spk_data_q;
    logic [TW-1:0] spk_step_q;
    logic          run_req;
    logic          abort_run;
    logic          last_step;
    logic          handshake;

    assign run_req   = bus.start && !bus.abort;
    assign abort_run = bus.abort && (state != S_IDLE);
    assign last_step = (t_q == num_q - TW'(1));
    assign handshake = (state == S_ACK) && spk_valid_q && bus.spk_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (run_req) begin
                    state_nx = (bus.num_steps == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: state_nx = S_FETCH;
            S_FETCH: state_nx = S_LOAD;
            S_LOAD:  state_nx = S_TICK;
            S_TICK:  state_nx = S_CAPT;
            S_CAPT:  state_nx = S_ACK;
            S_ACK: begin
                if (handshake) begin
                    state_nx = last_step ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort_run) begin
            state_nx = S_IDLE;
        end
    end

    // Strobes are registered from the next state so each is high exactly while its state is current.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ev_rd_en_q   <= 1'b0;
            core_clear_q <= 1'b0;
            core_tick_q  <= 1'b0;
        end else begin
            busy_q       <= (state_nx != S_IDLE);
            done_q       <= (state_nx == S_DONE);
            ev_rd_en_q   <= (state_nx == S_FETCH);
            core_clear_q <= (state_nx == S_CLEAR);
            core_tick_q  <= (state_nx == S_TICK);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            t_q         <= '0;
            num_q       <= '0;
            ev_vec_q    <= '0;
            spk_valid_q <= 1'b0;
            spk_data_q  <= '0;
            spk_step_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run_req) begin
                        num_q <= bus.num_steps;
                    end
                end
                S_CLEAR: t_q <= '0;
                S_LOAD:  ev_vec_q <= bus.ev_rd_data;
                S_CAPT: begin
                    spk_data_q  <= bus.core_spikes;
                    spk_step_q  <= t_q;
                    spk_valid_q <= 1'b1;
                end
                S_ACK: begin
                    if (handshake) begin
                        spk_valid_q <= 1'b0;
                        if (!last_step) begin
                            t_q <= t_q + TW'(1);
                        end
                    end
                end
                S_DONE:  ev_vec_q <= '0;
                default: ;
            endcase
            if (abort_run) begin
                spk_valid_q <= 1'b0;
                ev_vec_q    <= '0;
            end
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.ev_rd_en       = ev_rd_en_q;
    assign bus.ev_rd_addr     = t_q;
    assign bus.core_clear     = core_clear_q;
    assign bus.core_tick      = core_tick_q;
    assign bus.core_event_vec = ev_vec_q;
    assign bus.spk_valid      = spk_valid_q;
    assign bus.spk_data       = spk_data_q;
    assign bus.spk_step       = spk_step_q;

`ifdef SNN_SPIKE_COUNT_EN
    logic [31:0] spike_total_q;
    logic [32:0] spike_sum;

    function automatic logic [31:0] popcount(input logic [N-1:0] v);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

    assign spike_sum = {1'b0, spike_total_q} + {1'b0, popcount(bus.core_spikes)};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            spike_total_q <= '0;
        end else if (state == S_CLEAR) begin
            spike_total_q <= '0;
        end else if (state == S_CAPT) begin
            spike_total_q <= spike_sum[32] ? '1 : spike_sum[31:0];
        end
    end

    assign bus.spike_total = spike_total_q;
`else
    assign bus.spike_total = '0;
`endif

endmodule

// File: tb/tb_snn_run_ctrl.sv
// Randomized bench for snn_run_ctrl: memory/core responders plus a step-list reference model.
// Expected rows, timing and spike totals come from per-run plans built here, never from the DUT.
module tb_snn_run_ctrl;
    localparam int F  = 48;
    localparam int N  = 96;
    localparam int TW = 4;

    logic clk;
    logic rstn;

    snn_run_ctrl_if #(.F(F), .N(N), .TW(TW)) bus ();

    snn_run_ctrl #(.F(F), .N(N), .TW(TW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc_n = 0;
    int           c0;
    int           done_cyc;
    int           exp_k;
    int           n_rd, n_tick, n_clear, n_done;
    int           stall_step;
    int           stall_left;
    int unsigned  ready_pct;
    bit           noise_start;
    bit           rd_pend, tk_pend, hold_v;
    logic [TW-1:0] rd_addr;
    logic [127:0] held;
    logic [F-1:0] ev_mem [16];
    logic [N-1:0] plan [16];
    int           ones [16];
    longint       prev_total, exp_total;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    function automatic logic [F-1:0] rand_f();
        return F'({$urandom(), $urandom()});
    endfunction

    function automatic logic [N-1:0] rand_n();
        return N'({$urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [N-1:0] make_row(input int cnt_want);
        logic [N-1:0] r;
        int cnt;
        int idx;
        r = '0;
        cnt = 0;
        while (cnt < cnt_want) begin
            idx = int'($urandom_range(N - 1, 0));
            if (!r[idx]) begin
                r[idx] = 1'b1;
                cnt++;
            end
        end
        return r;
    endfunction

    task automatic set_ones_rand();
        for (int k = 0; k < 16; k++) ones[k] = int'($urandom_range(N, 1));
    endtask

    // One clock: drive responders and sink for the next edge, then check what the DUT shows now.
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        bus.ev_rd_data  = rd_pend ? ev_mem[rd_addr] : rand_f();
        rd_pend         = bus.ev_rd_en;
        rd_addr         = bus.ev_rd_addr;
        bus.core_spikes = tk_pend ? plan[exp_k[3:0]] : rand_n();
        tk_pend         = bus.core_tick;
        bus.spk_ready   = ($urandom_range(99, 0) < ready_pct);
        if (bus.spk_valid && exp_k == stall_step && stall_left > 0) begin
            bus.spk_ready = 1'b0;
            stall_left--;
        end
        if (noise_start) begin
            bus.start     = bus.busy && ($urandom_range(3, 0) == 0);
            bus.num_steps = TW'($urandom());
        end
        if (bus.ev_rd_en) begin
            n_rd++;
            chk("rd_addr", bus.ev_rd_addr, exp_k);
        end
        if (bus.core_tick) begin
            n_tick++;
            chk("event_vec", bus.core_event_vec, ev_mem[exp_k[3:0]]);
        end
        if (bus.core_clear) n_clear++;
        if (bus.done) begin
            n_done++;
            done_cyc = cyc_n;
        end
        if (bus.spk_valid) begin
            if (hold_v) chk("spk_hold", {bus.spk_data, bus.spk_step}, held);
            if (bus.spk_ready) begin
                chk("spk_step", bus.spk_step, exp_k);
                chk("spk_data", bus.spk_data, plan[exp_k[3:0]]);
                exp_k++;
                hold_v = 1'b0;
            end else begin
                hold_v = 1'b1;
                held   = {bus.spk_data, bus.spk_step};
            end
        end else begin
            hold_v = 1'b0;
        end
    endtask

    task automatic launch(input int t_steps);
        for (int k = 0; k < 16; k++) begin
            ev_mem[k] = rand_f();
            plan[k]   = make_row(ones[k]);
        end
        exp_k = 0; n_rd = 0; n_tick = 0; n_clear = 0; n_done = 0;
        done_cyc = -1;
        hold_v = 1'b0;
        if (t_steps == 0) begin
            exp_total = prev_total;
        end else begin
            exp_total = 0;
            for (int k = 0; k < t_steps; k++) exp_total += ones[k];
        end
`ifndef SNN_SPIKE_COUNT_EN
        exp_total = 0;
`endif
        cyc();
        bus.start     = 1'b1;
        bus.num_steps = TW'(t_steps);
        c0 = cyc_n;
        cyc();
        bus.start = 1'b0;
    endtask

    // exp_lat: cycles from the start-driving point to the cycle showing done; -1 skips the check.
    task automatic finish_run(input int t_steps, input int exp_lat);
        int guard;
        guard = 0;
        while (n_done == 0 && guard < 3000) begin
            cyc();
            guard++;
        end
        if (n_done == 0) chk("done_timeout", n_done, 1);
        else if (exp_lat >= 0) chk("done_lat", done_cyc - c0, exp_lat);
        chk("steps", exp_k, t_steps);
        chk("rd_cnt", n_rd, t_steps);
        chk("tick_cnt", n_tick, t_steps);
        chk("clear_cnt", n_clear, (t_steps > 0) ? 1 : 0);
        cyc();
        chk("done_pulse", {bus.done, bus.busy, bus.spk_valid}, '0);
        chk("evec_cleared", bus.core_event_vec, '0);
        chk("spike_total", bus.spike_total, exp_total);
        chk("done_cnt", n_done, 1);
        prev_total = exp_total;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {bus.busy, bus.done, bus.ev_rd_en, bus.core_clear, bus.core_tick,
                            bus.spk_valid, bus.ev_rd_addr, bus.spk_step, bus.spike_total}, '0);
        chk({tag, "_evec"}, bus.core_event_vec, '0);
        chk({tag, "_spk"}, bus.spk_data, '0);
    endtask

    function automatic int tied_lat(input int t_steps);
        return (t_steps == 0) ? 1 : 5 * t_steps + 2;
    endfunction

    initial begin
        int g;
        int t_rand;
        rstn = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.num_steps = '0;
        bus.ev_rd_data = '0; bus.core_spikes = '0; bus.spk_ready = 1'b0;
        ready_pct = 100; stall_step = -1; stall_left = 0; noise_start = 1'b0;
        rd_pend = 1'b0; tk_pend = 1'b0; hold_v = 1'b0; rd_addr = '0; held = '0;
        prev_total = 0; exp_total = 0;
        set_ones_rand();
        repeat (3) cyc();
        chk_zero("rst");
        rstn = 1'b1;

        // abort wins over start in IDLE
        cyc();
        bus.start = 1'b1; bus.abort = 1'b1; bus.num_steps = TW'(3);
        cyc();
        chk("abort_prio", bus.busy, 1'b0);
        bus.start = 1'b0; bus.abort = 1'b0;

        set_ones_rand(); launch(3);  finish_run(3, 17);
        set_ones_rand(); launch(0);  finish_run(0, 1);
        set_ones_rand(); launch(15); finish_run(15, tied_lat(15));

        // step 1 held back by the sink for 10 cycles
        stall_step = 1; stall_left = 10;
        set_ones_rand(); launch(3); finish_run(3, 27);
        stall_step = -1;

        // abort in TICK of step 2 of 5
        set_ones_rand(); launch(5);
        g = 0;
        while (!(bus.core_tick && exp_k == 2) && g < 100) begin cyc(); g++; end
        chk("abort_reach", exp_k, 2);
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        chk("abort_state", {bus.busy, bus.spk_valid, bus.core_tick, bus.done}, '0);
        chk("abort_evec", bus.core_event_vec, '0);
        repeat (5) cyc();
        chk("abort_no_done", n_done, 0);
        set_ones_rand(); launch(5); finish_run(5, tied_lat(5));

        // asynchronous reset while a row waits in ACK
        ready_pct = 0;
        set_ones_rand(); launch(4);
        g = 0;
        while (!bus.spk_valid && g < 50) begin cyc(); g++; end
        chk("ack_reach", bus.spk_valid, 1'b1);
        #1 rstn = 1'b0;
        #1 chk_zero("rst_ack");
        cyc(); cyc();
        rstn = 1'b1;
        rd_pend = 1'b0; tk_pend = 1'b0; hold_v = 1'b0; prev_total = 0;
        ready_pct = 100;
        repeat (4) cyc();
        chk("rst_no_done", n_done, 0);
        chk("rst_idle", bus.busy, 1'b0);
        set_ones_rand(); launch(2); finish_run(2, tied_lat(2));

        // fixed spike counts 3, 96, 0 then a fresh run
        ones[0] = 3; ones[1] = 96; ones[2] = 0;
        launch(3); finish_run(3, 17);
        set_ones_rand(); launch(2); finish_run(2, tied_lat(2));

        // random runs with a backpressuring sink and stray starts while busy
        noise_start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_ones_rand();
            t_rand    = int'($urandom_range(15, 0));
            ready_pct = (i % 3 == 0) ? 100 : $urandom_range(90, 30);
            launch(t_rand);
            finish_run(t_rand, (ready_pct == 100) ? tied_lat(t_rand) : -1);
        end
        noise_start = 1'b0;
        bus.start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
